// File: rtl/fabric_test_sequencer.sv
// One-shot test sequencer for the reconfigurable fabric: serial config load,
// settle, then per-vector apply / hold / check with a saturating mismatch count.
//
// Handshake: there is no valid/ready pair. start is a one-cycle request,
// honoured only in IDLE or DONE and ignored while busy. The ROMs answer
// cfg_addr/vec_addr in time for the edge that ends the cycle in which the
// address is presented. check_strobe marks the single cycle in which dataout
// is compared against expected_dataout.
module fabric_test_sequencer #(
  parameter int CONFIG_WIDTH        = 64,
  parameter int DATA_IN_WIRE_WIDTH  = 16,
  parameter int DATA_OUT_WIRE_WIDTH = 8,
  parameter int NUM_VECTORS         = 16,
  parameter int SETTLE_CYCLES       = 4,
  localparam int CAW = (CONFIG_WIDTH > 1) ? $clog2(CONFIG_WIDTH) : 1,
  localparam int VAW = (NUM_VECTORS > 1) ? $clog2(NUM_VECTORS) : 1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  output logic [CAW-1:0]                 cfg_addr,
  input  logic                           cfg_bit,
  output logic                           config_en,
  output logic                           config_in,
  output logic [VAW-1:0]                 vec_addr,
  input  logic [DATA_IN_WIRE_WIDTH-1:0]  vec_data,
  input  logic [DATA_OUT_WIRE_WIDTH-1:0] vec_expected,
  output logic [DATA_IN_WIRE_WIDTH-1:0]  datain,
  input  logic [DATA_OUT_WIRE_WIDTH-1:0] dataout,
  output logic [DATA_OUT_WIRE_WIDTH-1:0] expected_dataout,
  output logic                           check_strobe,
  output logic                           busy,
  output logic                           sim_done,
  output logic [15:0]                    error_count,
  output logic [2:0]                     fsm_state
);

  localparam int WW = $clog2(SETTLE_CYCLES + 1) + 1;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    CFG_SHIFT  = 3'd1,
    CFG_SETTLE = 3'd2,
    VEC_FETCH  = 3'd3,
    VEC_HOLD   = 3'd4,
    DONE       = 3'd5
  } state_t;

  state_t        state;
  logic [WW-1:0] wait_cnt;

  assign fsm_state = state;

  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= IDLE;
      wait_cnt         <= '0;
      cfg_addr         <= '0;
      config_en        <= 1'b0;
      config_in        <= 1'b0;
      vec_addr         <= '0;
      datain           <= '0;
      expected_dataout <= '0;
      check_strobe     <= 1'b0;
      busy             <= 1'b0;
      sim_done         <= 1'b0;
      error_count      <= '0;
    end else begin
      check_strobe <= 1'b0;

      // The compare happens in the strobe cycle; the count lands one cycle later.
      // Case inequality so an X/Z on dataout is counted as a mismatch.
      if (check_strobe && (dataout !== expected_dataout) && (error_count != 16'hFFFF))
        error_count <= error_count + 16'd1;

      case (state)
        IDLE, DONE: begin
          if (start) begin
            state       <= CFG_SHIFT;
            busy        <= 1'b1;
            sim_done    <= 1'b0;
            error_count <= '0;
            cfg_addr    <= '0;
            vec_addr    <= '0;
            config_en   <= 1'b0;
            config_in   <= 1'b0;
          end
        end

        CFG_SHIFT: begin
          config_en <= 1'b1;
          config_in <= cfg_bit;
          if (cfg_addr == CAW'(CONFIG_WIDTH - 1)) begin
            state    <= CFG_SETTLE;
            wait_cnt <= '0;
          end else begin
            cfg_addr <= cfg_addr + CAW'(1);
          end
        end

        // The first settle cycle still shows the last shifted bit, so the
        // state lasts SETTLE_CYCLES+1 cycles to give SETTLE_CYCLES quiet ones.
        CFG_SETTLE: begin
          config_en <= 1'b0;
          config_in <= 1'b0;
          if (wait_cnt == WW'(SETTLE_CYCLES)) begin
            state <= VEC_FETCH;
          end else begin
            wait_cnt <= wait_cnt + WW'(1);
          end
        end

        VEC_FETCH: begin
          datain           <= vec_data;
          expected_dataout <= vec_expected;
          wait_cnt         <= '0;
          state            <= VEC_HOLD;
          if (SETTLE_CYCLES == 1)
            check_strobe <= 1'b1;
        end

        VEC_HOLD: begin
          if (wait_cnt == WW'(SETTLE_CYCLES - 1)) begin
            if (vec_addr == VAW'(NUM_VECTORS - 1)) begin
              state    <= DONE;
              busy     <= 1'b0;
              sim_done <= 1'b1;
            end else begin
              vec_addr <= vec_addr + VAW'(1);
              state    <= VEC_FETCH;
            end
          end else begin
            wait_cnt <= wait_cnt + WW'(1);
            if ((SETTLE_CYCLES >= 2) && (wait_cnt == WW'(SETTLE_CYCLES - 2)))
              check_strobe <= 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
